// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller: walks an 8-bit trial from MSB to LSB
// against an external comparator. Optional early exit on equal: SAR_EARLY_EXIT_EN.
module sar_search_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [7:0] trial,
  input  logic       greater,
  input  logic       lesser,
  input  logic       equal,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic       flag_err
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SEARCH = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  logic [1:0] state;
  logic [2:0] ptr;
  logic [7:0] resolved;
  logic [7:0] next_trial;
  logic [1:0] flag_sum;
  logic       flags_bad;

  // Resolve the current bit: only lesser clears it, anything else keeps it set.
  always_comb begin
    resolved = trial;
    if (lesser) resolved[ptr] = 1'b0;
    next_trial = resolved;
    next_trial[ptr - 3'd1] = 1'b1;
    flag_sum  = {1'b0, greater} + {1'b0, lesser} + {1'b0, equal};
    flags_bad = (flag_sum != 2'd1);
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= 3'd7;
      trial    <= 8'h00;
      result   <= 8'h00;
      done     <= 1'b0;
      flag_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            ptr      <= 3'd7;
            trial    <= 8'h80;
            flag_err <= 1'b0;
            state    <= SEARCH;
          end
        end
        SEARCH: begin
          if (flags_bad) flag_err <= 1'b1;
`ifdef SAR_EARLY_EXIT_EN
          if (equal) begin
            result <= trial;
            done   <= 1'b1;
            state  <= FINISH;
          end else
`endif
          // Bit 0 is the last one; the pointer parks at 0 and trial keeps its last value.
          if (ptr == 3'd0) begin
            result <= resolved;
            done   <= 1'b1;
            state  <= FINISH;
          end else begin
            trial <= next_trial;
            ptr   <= ptr - 3'd1;
          end
        end
        FINISH: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
